fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 129 ++++++++++++
 tb/tb_fb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: camera write FIFO and display reads share one single-port RAM; display reads win. Macro FB_ARB_DROP_CNT_EN enables drop_cnt.
// Latency: RAM access is issued 1 cycle after arbitration; vga_data is valid 2 cycles after vga_req; a camera word reaches the RAM >= 2 cycles after push.
// Backpressure: cam_ready low while the FIFO is full; pushes offered while full are rejected and counted, never stalled.
module fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK25,
  input  logic              rst_n,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_ready,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_VGA  = 2'd1,
    G_CAM  = 2'd2
  } grant_t;

  wr_ent_t          fifo_mem [FIFO_DEPTH];
  wr_ent_t          head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  grant_t           g_state;

  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = cam_we & ~full;
  assign pop       = ~vga_req & ~empty;
  assign cam_ready = ~full;
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge CLK25) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: cam_addr, data: cam_data};
    end
  end

  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Grant FSM: state and RAM port reflect the access issued in the following cycle.
  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      g_state   <= G_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vga_valid <= 1'b0;
    end else begin
      vga_valid <= (g_state == G_VGA);
      if (vga_req) begin
        g_state  <= G_VGA;
        mem_we   <= 1'b0;
        mem_addr <= vga_addr;
      end else if (!empty) begin
        g_state   <= G_CAM;
        mem_we    <= 1'b1;
        mem_addr  <= head.addr;
        mem_wdata <= head.data;
      end else begin
        g_state <= G_IDLE;
        mem_we  <= 1'b0;
      end
    end
  end

  // RAM read data lands in the cycle after the read is issued, so it is gated rather than re-registered.
  assign vga_data = vga_valid ? mem_rdata : '0;

`ifdef FB_ARB_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = cam_we & full;

  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: write path, read pipeline, priority stall, full-FIFO rejection, drop saturation, reset.
module tb_fb_arbiter;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 16;
`ifdef FB_ARB_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic              CLK25 = 1'b0;
  logic              rst_n;
  logic              cam_we;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_data;
  logic              cam_ready;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       drop_cnt;

  int total = 0;
  int bad   = 0;

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK25(CLK25), .rst_n(rst_n),
    .cam_we(cam_we), .cam_addr(cam_addr), .cam_data(cam_data), .cam_ready(cam_ready),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .drop_cnt(drop_cnt)
  );

  always #20 CLK25 = ~CLK25;

  // Synchronous-read RAM model with a fixed content pattern.
  function automatic logic [15:0] rd_pattern(input logic [ADDR_W-1:0] a);
    if (a == 17'h12BFF) return 16'h07E0;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge CLK25) mem_rdata <= rd_pattern(mem_addr);

  task automatic do_reset;
    rst_n = 1'b0; cam_we = 1'b0; vga_req = 1'b0;
    cam_addr = '0; cam_data = '0; vga_addr = '0;
    @(negedge CLK25);
    @(negedge CLK25);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cam_we = 1'b1; vga_req = 1'b1;
    cam_addr = 17'h00AAA; cam_data = 16'h1234; vga_addr = 17'h00BBB;
    @(negedge CLK25);
    @(negedge CLK25);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    total++; if (mem_addr !== 17'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 16'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (vga_valid !== 1'b0) begin bad++; $display("FAIL rst_vga_valid got=%0b exp=0", vga_valid); end
    total++; if (vga_data !== 16'h0) begin bad++; $display("FAIL rst_vga_data got=%h exp=0", vga_data); end
    total++; if (cam_ready !== 1'b1) begin bad++; $display("FAIL rst_cam_ready got=%0b exp=1", cam_ready); end
    total++; if (drop_cnt !== 16'h0) begin bad++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
    cam_we = 1'b0; vga_req = 1'b0; rst_n = 1'b1;
    @(negedge CLK25);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_release_we got=%0b exp=0", mem_we); end
    @(negedge CLK25);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_no_push got=%0b exp=0", mem_we); end
  endtask

  task automatic test_write;
    do_reset();
    cam_we = 1'b1; cam_addr = 17'h00005; cam_data = 16'hF800;
    @(negedge CLK25);
    cam_we = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_early_we got=%0b exp=0", mem_we); end
    @(negedge CLK25);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%0b exp=1", mem_we); end
    total++; if (mem_addr !== 17'h00005) begin bad++; $display("FAIL wr_addr got=%h exp=00005", mem_addr); end
    total++; if (mem_wdata !== 16'hF800) begin bad++; $display("FAIL wr_data got=%h exp=f800", mem_wdata); end
    @(negedge CLK25);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_idle_we got=%0b exp=0", mem_we); end
    total++; if (mem_addr !== 17'h00005) begin bad++; $display("FAIL wr_idle_hold got=%h exp=00005", mem_addr); end
  endtask

  task automatic test_read;
    do_reset();
    vga_req = 1'b1; vga_addr = 17'h12BFF;
    @(negedge CLK25);
    vga_addr = 17'h00010;
    total++; if (mem_addr !== 17'h12BFF) begin bad++; $display("FAIL rd_mem_addr got=%h exp=12bff", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_mem_we got=%0b exp=0", mem_we); end
    total++; if (vga_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_n1 got=%0b exp=0", vga_valid); end
    @(negedge CLK25);
    vga_addr = 17'h00011;
    total++; if (vga_valid !== 1'b1) begin bad++; $display("FAIL rd_valid_n2 got=%0b exp=1", vga_valid); end
    total++; if (vga_data !== 16'h07E0) begin bad++; $display("FAIL rd_data_n2 got=%h exp=07e0", vga_data); end
    @(negedge CLK25);
    vga_req = 1'b0;
    total++; if (vga_valid !== 1'b1) begin bad++; $display("FAIL rd_b2b_valid1 got=%0b exp=1", vga_valid); end
    total++; if (vga_data !== 16'h5A4A) begin bad++; $display("FAIL rd_b2b_data1 got=%h exp=5a4a", vga_data); end
    @(negedge CLK25);
    total++; if (vga_data !== 16'h5A4B) begin bad++; $display("FAIL rd_b2b_data2 got=%h exp=5a4b", vga_data); end
    @(negedge CLK25);
    total++; if (vga_valid !== 1'b0) begin bad++; $display("FAIL rd_end_valid got=%0b exp=0", vga_valid); end
    total++; if (vga_data !== 16'h0) begin bad++; $display("FAIL rd_end_data got=%h exp=0", vga_data); end
  endtask

  task automatic test_back_to_back;
    logic exp_we;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cam_we   = (c < 4);
      cam_addr = 17'h00040 + 17'(c);
      cam_data = 16'hA000 + 16'(c);
      @(negedge CLK25);
      exp_we = (c + 1 >= 2) && (c + 1 <= 5);
      total++; if (mem_we !== exp_we) begin bad++; $display("FAIL b2b_we cyc=%0d got=%0b exp=%0b", c + 1, mem_we, exp_we); end
      if (exp_we) begin
        total++;
        if (mem_addr !== 17'h00040 + 17'(c - 1) || mem_wdata !== 16'hA000 + 16'(c - 1)) begin
          bad++; $display("FAIL b2b_order cyc=%0d got=%h/%h exp=%h/%h", c + 1, mem_addr, mem_wdata,
                          17'h00040 + 17'(c - 1), 16'hA000 + 16'(c - 1));
        end
      end
    end
    total++; if (mem_addr !== 17'h00043) begin bad++; $display("FAIL b2b_hold got=%h exp=00043", mem_addr); end
  endtask

  task automatic test_stall;
    logic [15:0] exp_drop;
    do_reset();
    for (int i = 0; i < 320; i++) begin
      total++; if (cam_ready !== (i <= 30)) begin bad++; $display("FAIL stall_ready i=%0d got=%0b exp=%0b", i, cam_ready, (i <= 30)); end
      if (i >= 1) begin
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL stall_we i=%0d got=%0b exp=0", i, mem_we); end
      end
      vga_req  = 1'b1;
      vga_addr = 17'(i);
      cam_we   = (i % 2 == 0);
      cam_addr = 17'h00100 + 17'(i);
      cam_data = 16'h1000 + 16'(i);
      @(negedge CLK25);
    end
    exp_drop = DROP_EN ? 16'd144 : 16'd0;
    total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL stall_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    vga_req = 1'b0; cam_we = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL stall_last_read got=%0b exp=0", mem_we); end
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK25);
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 17'h00100 + 17'(2 * k) || mem_wdata !== 16'h1000 + 16'(2 * k)) begin
        bad++; $display("FAIL stall_drain k=%0d got=%0b/%h/%h exp=1/%h/%h", k, mem_we, mem_addr, mem_wdata,
                        17'h00100 + 17'(2 * k), 16'h1000 + 16'(2 * k));
      end
    end
    @(negedge CLK25);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL stall_drained got=%0b exp=0", mem_we); end
    total++; if (mem_addr !== 17'h0011E) begin bad++; $display("FAIL stall_hold got=%h exp=0011e", mem_addr); end
  endtask

  task automatic test_full_pop;
    logic [15:0] exp_drop;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      vga_req = 1'b1; cam_we = 1'b1;
      cam_addr = 17'h00200 + 17'(i); cam_data = 16'hC000 + 16'(i);
      @(negedge CLK25);
    end
    total++; if (cam_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", cam_ready); end
    vga_req = 1'b0; cam_we = 1'b1; cam_addr = 17'h003FF; cam_data = 16'hDEAD;
    @(negedge CLK25);
    cam_we = 1'b0;
    exp_drop = DROP_EN ? 16'd1 : 16'd0;
    total++; if (cam_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%0b exp=1", cam_ready); end
    total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL full_pop_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 17'h00200 + 17'(k)) begin
        bad++; $display("FAIL full_drain k=%0d got=%0b/%h exp=1/%h", k, mem_we, mem_addr, 17'h00200 + 17'(k));
      end
      @(negedge CLK25);
    end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL full_rejected_written got=%0b/%h exp=0", mem_we, mem_addr); end
  endtask

  task automatic test_saturate;
    do_reset();
    vga_req = 1'b1; cam_we = 1'b1; cam_addr = 17'h00077; cam_data = 16'h7777;
    repeat (16) @(negedge CLK25);
    repeat (65534) @(negedge CLK25);
    total++; if (drop_cnt !== (DROP_EN ? 16'hFFFE : 16'h0)) begin bad++; $display("FAIL sat_pre got=%h exp=%h", drop_cnt, DROP_EN ? 16'hFFFE : 16'h0); end
    @(negedge CLK25);
    total++; if (drop_cnt !== (DROP_EN ? 16'hFFFF : 16'h0)) begin bad++; $display("FAIL sat_hit got=%h exp=%h", drop_cnt, DROP_EN ? 16'hFFFF : 16'h0); end
    repeat (5) @(negedge CLK25);
    total++; if (drop_cnt !== (DROP_EN ? 16'hFFFF : 16'h0)) begin bad++; $display("FAIL sat_hold got=%h exp=%h", drop_cnt, DROP_EN ? 16'hFFFF : 16'h0); end
    total++; if (cam_ready !== 1'b0) begin bad++; $display("FAIL sat_ready got=%0b exp=0", cam_ready); end
    vga_req = 1'b0; cam_we = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      vga_req = 1'b1; vga_addr = 17'h12BFF;
      cam_we = 1'b1; cam_addr = 17'h00300 + 17'(i); cam_data = 16'hB000 + 16'(i);
      @(negedge CLK25);
    end
    cam_we = 1'b0;
    @(negedge CLK25);
    total++; if (vga_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%0b exp=1", vga_valid); end
    rst_n = 1'b0; vga_req = 1'b0;
    @(negedge CLK25);
    rst_n = 1'b1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%0b exp=0", mem_we); end
    total++; if (vga_valid !== 1'b0 || vga_data !== 16'h0) begin bad++; $display("FAIL mid_read_killed got=%0b/%h exp=0/0", vga_valid, vga_data); end
    total++; if (cam_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b exp=1", cam_ready); end
    total++; if (drop_cnt !== 16'h0) begin bad++; $display("FAIL mid_drop got=%0d exp=0", drop_cnt); end
    total++; if (mem_addr !== 17'h0) begin bad++; $display("FAIL mid_addr got=%h exp=0", mem_addr); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK25);
      total++; if (mem_we !== 1'b0 || vga_valid !== 1'b0) begin bad++; $display("FAIL mid_after k=%0d got=%0b/%0b exp=0/0", k, mem_we, vga_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0; cam_we = 1'b0; vga_req = 1'b0;
    cam_addr = '0; cam_data = '0; vga_addr = '0;
    @(negedge CLK25);
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_stall();
    test_full_pop();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
